ifu_decd: RTL and testbench
===========================

Name: ifu_decd

Overview:
- Instruction fetch/decode stage directly upstream of the multicycle control unit.
- Holds the PC and fetches one 32-bit word per request over a req/ack instruction-memory handshake.
- Latches the word into an instruction register (IR) and drives the 7-bit decoded opcode (decdOp) and register/immediate fields consumed by control and datapath.
- Computes and commits the next PC from control's nPCOp/zero on an update strobe.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- TMO_CYC, 16, max cycles in WAIT before fetch error (used only with IFU_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state on posedge.
- clr  in  1  asynchronous, active-low reset.
- fetch  in  1  one-cycle pulse from control: start fetch at current PC.
- pc_upd  in  1  one-cycle pulse: commit next PC.
- nPCOp  in  2  00 nml, 01 beq, 10 j, 11 treated as nml.
- zero  in  1  ALU zero flag, sampled with pc_upd.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address = PC.
- imem_ack  in  1  memory has data valid this cycle.
- imem_rdata  in  32  instruction word.
- ir_valid  out  1  one-cycle pulse: IR just loaded.
- busy  out  1  fetch in progress.
- decdOp  out  7  decoded opcode class.
- illegal  out  1  IR holds an unsupported instruction.
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- imm16  out  16  IR[15:0].
- imm26  out  26  IR[25:0].
- pc  out  32  current PC.
- fetch_err  out  1  sticky timeout flag (IFU_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (clr=0, async):
  - pc=PC_RESET, IR=32'h0, FSM=IDLE.
  - imem_req=0, ir_valid=0, busy=0, fetch_err=0.
  - decdOp=0 (nop), illegal=0. A decode of IR=0 (sll $0) yields decdOp=0 with illegal masked to 0 for the all-zero word only.
  - Reset mid-fetch aborts immediately; any late imem_ack is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: fetch=1 -> REQ.
  - REQ: imem_req=1, imem_addr=pc, busy=1. imem_ack=1 in the same cycle -> load IR, ->IDLE; else ->WAIT.
  - WAIT: imem_req held 1, address stable. imem_ack=1 -> load IR, ->IDLE.
  - ir_valid=1 for exactly the cycle after the IR load.
  - busy=1 in REQ/WAIT; 0 otherwise.
- fetch pulses are ignored while busy=1 (no queuing).
- Decode is combinational from IR: op=IR[31:26], funct=IR[5:0].
  - op 0, funct 0x21 -> 7'b1000011 (addu)
  - op 0, funct 0x23 -> 7'b1000111 (subu)
  - op 0x0D -> 7'b0011010 (ori)
  - op 0x23 -> 7'b1000110 (lw)
  - op 0x2B -> 7'b1010110 (sw)
  - op 0x04 -> 7'b0001000 (beq)
  - op 0x02 -> 7'b0000100 (j)
  - anything else -> decdOp=0, illegal=1 (except IR==0).
- Next-PC (combinational; registered on pc_upd):
  - pc4 = pc + 4.
  - nml -> pc4.
  - beq -> zero ? pc4 + ({{14{imm16[15]}}, imm16, 2'b00}) : pc4.
  - j -> {pc[31:28], imm26, 2'b00}.
  - All arithmetic is 32-bit modulo 2^32; pc=32'hFFFF_FFFC with nml wraps to 0.
- pc_upd while busy=1 is ignored. PC and imem_addr never change mid-handshake.
- pc_upd and fetch in the same cycle in IDLE: PC updates first, and the fetch uses the new PC at REQ.
- IR and decoded outputs hold until the next IR load; pc holds until pc_upd.

Optional Feature:
- IFU_TIMEOUT_EN defined:
  - 5-bit wait counter clears on entry to REQ and increments each WAIT cycle.
  - Counter reaching TMO_CYC without ack -> drop imem_req, set fetch_err (sticky until reset), ->IDLE with IR unchanged and no ir_valid.
- Not defined: WAIT waits indefinitely, no counter logic, fetch_err tied 0.

Test Plan:
- Reset release, fetch pulse, ack same cycle with rdata=32'h0211_8021 -> imem_addr=32'h3000, IR loaded, ir_valid one cycle, decdOp=7'b1000011, rs=16, rt=17, rd=16.
- Fetch with ack delayed 3 cycles, rdata=32'h8C08_0004 -> imem_req high 4 cycles with address stable, busy=1 throughout, decdOp=7'b1000110, imm16=4.
- IR=beq (32'h1109_FFFF), pc=32'h3008, nPCOp=01:
  - zero=1, pc_upd -> pc=32'h3008.
  - zero=0 -> pc=32'h300C.
- IR=j (32'h0800_0C10), pc=32'h3010, nPCOp=10, pc_upd -> pc=32'h0000_3040. Then rdata=32'hFC00_0000 -> illegal=1, decdOp=0.
- clr asserted during WAIT, then late imem_ack -> imem_req drops immediately, pc=32'h3000, no IR load, no ir_valid; a fetch pulse or pc_upd during busy has no effect.
- IFU_TIMEOUT_EN build, ack never arrives -> after 16 WAIT cycles imem_req=0, fetch_err=1 and stays set. Non-EN build -> request held indefinitely.

Source files
------------

// File: rtl/ifu_decd_if.sv
// Instruction-memory port of the fetch/decode stage.
// The IFU raises imem_req with imem_addr and holds both unchanged until the memory
// answers with imem_ack high for one cycle, imem_rdata valid in that same cycle.
interface ifu_decd_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifu_decd.sv
// Fetch/decode stage: PC, IR, opcode decode and next-PC for the multicycle control.
// Optional fetch timeout is built when IFU_TIMEOUT_EN is defined.
module ifu_decd #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          TMO_CYC  = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        fetch,
    input  logic        pc_upd,
    input  logic [1:0]  nPCOp,
    input  logic        zero,
    ifu_decd_if.master  imem,
    output logic        ir_valid,
    output logic        busy,
    output logic [6:0]  decdOp,
    output logic        illegal,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [25:0] imm26,
    output logic [31:0] pc,
    output logic        fetch_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [31:0] ir;
    logic [31:0] pc_q;
    logic [31:0] pc4, npc;
    logic        ir_load;
    logic        req;
    logic        ir_valid_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= S_IDLE;
            ir         <= 32'h0;
            pc_q       <= PC_RESET;
            ir_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            ir_valid_q <= ir_load;
            if (ir_load)
                ir <= imem.imem_rdata;
            // PC only moves between fetches so imem_addr stays stable mid-handshake
            if (pc_upd && state == S_IDLE)
                pc_q <= npc;
        end
    end

`ifdef IFU_TIMEOUT_EN
    logic [4:0] wcnt;
    logic       tmo;
    logic       err_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wcnt  <= 5'd0;
            err_q <= 1'b0;
        end else begin
            if (state == S_REQ)
                wcnt <= 5'd0;
            else if (state == S_WAIT)
                wcnt <= wcnt + 5'd1;
            if (tmo)
                err_q <= 1'b1;
        end
    end

    // Timeout fires on the TMO_CYC-th WAIT cycle without an ack
    assign tmo       = (state == S_WAIT) && !imem.imem_ack && (wcnt == 5'(TMO_CYC - 1));
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        ir_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fetch)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = S_IDLE;
                end
`ifdef IFU_TIMEOUT_EN
                else if (tmo) begin
                    state_nxt = S_IDLE;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc4 = pc_q + 32'd4;
        case (nPCOp)
            2'b01:   npc = zero ? pc4 + {{14{ir[15]}}, ir[15:0], 2'b00} : pc4;
            2'b10:   npc = {pc_q[31:28], ir[25:0], 2'b00};
            default: npc = pc4;
        endcase
    end

    // The all-zero word is the canonical nop and is never flagged illegal
    always_comb begin
        decdOp  = 7'b0000000;
        illegal = 1'b0;
        case (ir[31:26])
            6'h00: begin
                if (ir[5:0] == 6'h21)
                    decdOp = 7'b1000011;
                else if (ir[5:0] == 6'h23)
                    decdOp = 7'b1000111;
                else
                    illegal = (ir != 32'h0);
            end
            6'h0D:   decdOp = 7'b0011010;
            6'h23:   decdOp = 7'b1000110;
            6'h2B:   decdOp = 7'b1010110;
            6'h04:   decdOp = 7'b0001000;
            6'h02:   decdOp = 7'b0000100;
            default: illegal = 1'b1;
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign ir_valid       = ir_valid_q;
    assign busy           = (state != S_IDLE);
    assign rs             = ir[25:21];
    assign rt             = ir[20:16];
    assign rd             = ir[15:11];
    assign imm16          = ir[15:0];
    assign imm26          = ir[25:0];
    assign pc             = pc_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_ifu_decd.sv
// Bench for ifu_decd: directed fetch/next-PC sequences plus a random fetch phase.
// Decode expectations are queued at fetch time and popped on each ir_valid pulse.
module tb_ifu_decd;

    logic        clk = 1'b0;
    logic        clr;
    logic        fetch;
    logic        pc_upd;
    logic [1:0]  nPCOp;
    logic        zero;
    logic        ir_valid, busy, illegal, fetch_err;
    logic [6:0]  decdOp;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] pc;
    logic [1:0]  state_dbg;

    int n_chk  = 0;
    int n_fail = 0;
    logic [95:0] exp_q[$];
    logic [31:0] exp_pc;

    ifu_decd_if bus();

    ifu_decd dut (
        .clk       (clk),
        .clr       (clr),
        .fetch     (fetch),
        .pc_upd    (pc_upd),
        .nPCOp     (nPCOp),
        .zero      (zero),
        .imem      (bus.master),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .decdOp    (decdOp),
        .illegal   (illegal),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm16     (imm16),
        .imm26     (imm26),
        .pc        (pc),
        .fetch_err (fetch_err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [95:0] pack(input logic [6:0] op, input logic ill, input logic [31:0] w);
        return {31'b0, op, ill, w[25:21], w[20:16], w[15:11], w[15:0], w[25:0]};
    endfunction

    // Scoreboard: every ir_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (ir_valid) begin
            if (exp_q.size() == 0)
                chk("ir_valid_unexpected", 96'd1, 96'd0);
            else
                chk("decode", {31'b0, decdOp, illegal, rs, rt, rd, imm16, imm26}, exp_q.pop_front());
        end
    end

    task automatic do_fetch(input logic [31:0] word, input int dly, input logic [31:0] addr,
                            input logic [6:0] op, input logic ill);
        @(negedge clk);
        fetch = 1'b1;
        exp_q.push_back(pack(op, ill, word));
        @(negedge clk);
        fetch = 1'b0;
        for (int i = 0; i <= dly; i++) begin
            chk("req_high", 96'(bus.imem_req), 96'd1);
            chk("addr_stable", 96'(bus.imem_addr), 96'(addr));
            chk("busy_high", 96'(busy), 96'd1);
            if (i == dly) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = word;
            end
            @(negedge clk);
        end
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        chk("ir_valid_pulse", 96'(ir_valid), 96'd1);
        chk("busy_done", 96'(busy), 96'd0);
        chk("req_done", 96'(bus.imem_req), 96'd0);
        @(negedge clk);
        chk("ir_valid_one_cycle", 96'(ir_valid), 96'd0);
    endtask

    task automatic upd(input logic [1:0] op, input logic z, input logic [31:0] exp);
        @(negedge clk);
        nPCOp  = op;
        zero   = z;
        pc_upd = 1'b1;
        @(negedge clk);
        pc_upd = 1'b0;
        chk("pc_next", 96'(pc), 96'(exp));
    endtask

    logic [31:0] tbl_word [10] = '{32'h0211_8021, 32'h0109_5023, 32'h3421_0001, 32'h8C08_0004,
                                   32'hAC09_0008, 32'h1109_FFFF, 32'h0800_0C10, 32'hFC00_0000,
                                   32'h0000_0000, 32'h0211_8020};
    logic [6:0]  tbl_op   [10] = '{7'b1000011, 7'b1000111, 7'b0011010, 7'b1000110,
                                   7'b1010110, 7'b0001000, 7'b0000100, 7'b0000000,
                                   7'b0000000, 7'b0000000};
    logic        tbl_ill  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0; fetch = 1'b0; pc_upd = 1'b0; nPCOp = 2'b00; zero = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", 96'(bus.imem_req), 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_ir_valid", 96'(ir_valid), 96'd0);
        chk("rst_pc", 96'(pc), 96'h3000);
        chk("rst_addr", 96'(bus.imem_addr), 96'h3000);
        chk("rst_decdOp", 96'(decdOp), 96'd0);
        chk("rst_illegal", 96'(illegal), 96'd0);
        chk("rst_fetch_err", 96'(fetch_err), 96'd0);
        clr = 1'b1;

        // addu, ack in the request cycle: rs=16 rt=17 rd=16
        do_fetch(32'h0211_8021, 0, 32'h3000, 7'b1000011, 1'b0);
        chk("addu_rs", 96'(rs), 96'd16);
        chk("addu_rt", 96'(rt), 96'd17);
        chk("addu_rd", 96'(rd), 96'd16);
        upd(2'b00, 1'b0, 32'h3004);
        // lw with ack delayed three cycles: four request cycles
        do_fetch(32'h8C08_0004, 3, 32'h3004, 7'b1000110, 1'b0);
        chk("lw_imm16", 96'(imm16), 96'd4);
        upd(2'b00, 1'b0, 32'h3008);
        do_fetch(32'h1109_FFFF, 1, 32'h3008, 7'b0001000, 1'b0);
        upd(2'b01, 1'b1, 32'h3008);
        upd(2'b01, 1'b0, 32'h300C);
        upd(2'b00, 1'b1, 32'h3010);
        do_fetch(32'h0800_0C10, 2, 32'h3010, 7'b0000100, 1'b0);
        upd(2'b10, 1'b0, 32'h3040);
        do_fetch(32'hFC00_0000, 0, 32'h3040, 7'b0000000, 1'b1);
        chk("illegal_hold", 96'(illegal), 96'd1);
        upd(2'b11, 1'b0, 32'h3044);
        // beq with most negative offset wraps below zero, then j to the top word
        do_fetch(32'h1000_8000, 0, 32'h3044, 7'b0001000, 1'b0);
        upd(2'b01, 1'b1, 32'hFFFE_3048);
        do_fetch(32'h0BFF_FFFF, 1, 32'hFFFE_3048, 7'b0000100, 1'b0);
        upd(2'b10, 1'b0, 32'hFFFF_FFFC);
        upd(2'b00, 1'b0, 32'h0000_0000);

        // fetch and pc_upd together in IDLE: the request goes out at the new PC
        @(negedge clk);
        fetch = 1'b1; pc_upd = 1'b1; nPCOp = 2'b00;
        exp_q.push_back(pack(7'b0011010, 1'b0, 32'h3421_0001));
        @(negedge clk);
        fetch = 1'b0; pc_upd = 1'b0;
        chk("same_cycle_addr", 96'(bus.imem_addr), 96'h4);
        chk("same_cycle_req", 96'(bus.imem_req), 96'd1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3421_0001;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("same_cycle_ir_valid", 96'(ir_valid), 96'd1);
        exp_pc = 32'h4;

        for (int n = 0; n < 12; n++) begin
            int k;
            k = $urandom_range(0, 9);
            do_fetch(tbl_word[k], $urandom_range(0, 5), exp_pc, tbl_op[k], tbl_ill[k]);
            if ($urandom_range(0, 1) == 1) begin
                exp_pc = exp_pc + 32'd4;
                upd(2'b00, 1'b0, exp_pc);
            end
        end

`ifdef IFU_TIMEOUT_EN
        begin
            int hi;
            hi = 0;
            @(negedge clk); fetch = 1'b1;
            @(negedge clk); fetch = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (bus.imem_req) hi++;
                @(negedge clk);
            end
            chk("tmo_req_cycles", 96'(hi), 96'd17);
            chk("tmo_req_low", 96'(bus.imem_req), 96'd0);
            chk("tmo_err", 96'(fetch_err), 96'd1);
            chk("tmo_pc", 96'(pc), 96'(exp_pc));
            repeat (5) @(negedge clk);
            chk("tmo_err_sticky", 96'(fetch_err), 96'd1);
        end
`else
        begin
            int hi;
            hi = 0;
            @(negedge clk); fetch = 1'b1;
            exp_q.push_back(pack(7'b1010110, 1'b0, 32'hAC09_0008));
            @(negedge clk); fetch = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (bus.imem_req) hi++;
                @(negedge clk);
            end
            chk("hold_req_cycles", 96'(hi), 96'd40);
            chk("hold_no_err", 96'(fetch_err), 96'd0);
            bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAC09_0008;
            @(negedge clk);
            bus.imem_ack = 1'b0;
            chk("hold_ir_valid", 96'(ir_valid), 96'd1);
        end
`endif

        // fetch and pc_upd while busy are ignored, then reset aborts the fetch
        @(negedge clk); fetch = 1'b1;
        @(negedge clk); fetch = 1'b0;
        @(negedge clk);
        fetch = 1'b1; pc_upd = 1'b1; nPCOp = 2'b10;
        @(negedge clk);
        fetch = 1'b0; pc_upd = 1'b0;
        chk("busy_upd_pc", 96'(pc), 96'(exp_pc));
        chk("busy_upd_addr", 96'(bus.imem_addr), 96'(exp_pc));
        chk("busy_upd_req", 96'(bus.imem_req), 96'd1);
        #2 clr = 1'b0;
        #1;
        chk("abort_req", 96'(bus.imem_req), 96'd0);
        chk("abort_busy", 96'(busy), 96'd0);
        chk("abort_pc", 96'(pc), 96'h3000);
        chk("abort_err", 96'(fetch_err), 96'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0211_8021;
        @(negedge clk);
        clr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_req", 96'(bus.imem_req), 96'd0);
            chk("late_ack_ir_valid", 96'(ir_valid), 96'd0);
        end
        bus.imem_ack = 1'b0;
        chk("late_ack_decdOp", 96'(decdOp), 96'd0);
        chk("late_ack_illegal", 96'(illegal), 96'd0);
        repeat (2) @(negedge clk);
        chk("queue_drained", 96'(exp_q.size()), 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
